// File: rtl/ring_decoder.sv
// ring_decoder: checks and decodes the one-hot output of a WIDTH-bit ring counter.
// Ports: clk, rst (sync, active-high), in_valid, ring_in[WIDTH] in;
//        idx[IDX_W], idx_valid, locked, err_pulse, err_count[ERR_CNT_W] out.
module ring_decoder #(
    parameter int WIDTH     = 4,
    parameter int LOCK_CNT  = 2,
    parameter int ERR_CNT_W = 8,
    parameter int IDX_W     = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     ring_in,
    output logic [IDX_W-1:0]     idx,
    output logic                 idx_valid,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int GW = $clog2(LOCK_CNT + 1);

    localparam logic [0:0] S_HUNT   = 1'b0;
    localparam logic [0:0] S_LOCKED = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] prev;
    logic             prev_valid;
    logic [GW-1:0]    good_cnt;

    logic             legal;
    logic [IDX_W-1:0] enc;
    logic [WIDTH-1:0] expected;
    logic             match;
    logic [GW-1:0]    good_nxt;

    // one-hot: nonzero and clearing the lowest set bit leaves nothing
    assign legal = (ring_in != '0) &&
                   ((ring_in & (ring_in - WIDTH'(1))) == '0);

    always_comb begin
        enc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (ring_in[i]) enc = IDX_W'(i);
        end
    end

    // next code is prev rotated left by one, MSB wrapping into LSB
    assign expected = {prev[WIDTH-2:0], prev[WIDTH-1]};
    assign match    = legal && prev_valid && (ring_in == expected);
    assign good_nxt = good_cnt + GW'(1);

    assign locked = (state == S_LOCKED);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_HUNT;
            prev       <= '0;
            prev_valid <= 1'b0;
            good_cnt   <= '0;
            idx        <= '0;
            idx_valid  <= 1'b0;
            err_pulse  <= 1'b0;
            err_count  <= '0;
        end else begin
            idx_valid <= 1'b0;
            err_pulse <= 1'b0;
            if (in_valid) begin
                if (legal) begin
                    idx       <= enc;
                    idx_valid <= 1'b1;
                    prev      <= ring_in;
                end
                prev_valid <= legal;
                if (state == S_HUNT) begin
                    if (match) begin
                        good_cnt <= good_nxt;
                        if (good_nxt >= GW'(LOCK_CNT)) state <= S_LOCKED;
                    end else begin
                        good_cnt <= '0;
                    end
                end else if (!match) begin
                    // any deviation while tracking is a sequence error
                    state     <= S_HUNT;
                    good_cnt  <= '0;
                    err_pulse <= 1'b1;
                    if (err_count != '1) err_count <= err_count + ERR_CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/ring_decoder.md
Name: ring_decoder

Overview:
- Receive-side companion to the WIDTH-bit one-hot ring counter.
- Samples the counter's one-hot output and converts it to a binary index.
- Checks that each sample is the single-step rotation of the previous sample.
- Locks onto a valid sequence and reports and counts sequence errors; used as an in-system checker and decoder on the counter output bus.

Parameters:
- WIDTH, 4, ring width in bits (>= 2); must match the driving ring counter.
- LOCK_CNT, 2, consecutive correct rotations required to enter LOCKED (>= 1).
- ERR_CNT_W, 8, width of the saturating error counter.
- IDX_W, $clog2(WIDTH), index width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  ring_in is sampled on this edge.
- ring_in  input  WIDTH  one-hot ring code from the counter.
- idx  output  IDX_W  binary position of the set bit in the last legal sample.
- idx_valid  output  1  one-cycle strobe: idx updated from a legal one-hot sample.
- locked  output  1  decoder is tracking a correct rotation sequence.
- err_pulse  output  1  one-cycle strobe: sequence error detected while LOCKED.
- err_count  output  ERR_CNT_W  saturating count of err_pulse events.

Behaviour:
- Clock and reset:
  - Single clock domain; rst is synchronous, active-high, and overrides all other inputs.
  - Reset values: idx=0, idx_valid=0, locked=0, err_pulse=0, err_count=0, state=HUNT, prev_valid=0, good_cnt=0.
- Legal code:
  - Exactly one bit set. 0 and multi-hot codes are illegal.
  - idx = position of the set bit (0001->0, 1000->3 for WIDTH=4).
- Expected next code:
  - Rotate-left by one of the previous legal sample, wrapping MSB->LSB (1000 -> 0001).
  - Equivalently, index (prev_idx+1) mod WIDTH.
- Sampling:
  - All outputs are registered; latency is 1 cycle from the sampling edge to idx/idx_valid/locked/err_pulse.
  - in_valid=0: no state change; idx holds; idx_valid=0; err_pulse=0. Gaps do not break sequence continuity.
- Output strobes:
  - idx_valid=1 for every legal sample, in either state.
  - On an illegal sample, idx holds and idx_valid=0.
- FSM, state HUNT:
  - Legal sample with prev_valid=0: store as prev; set prev_valid=1; good_cnt=0.
  - Legal sample equal to the expected code: good_cnt+1. If good_cnt reaches LOCK_CNT, go to LOCKED; locked=1 in the same output cycle as that sample's idx.
  - Legal sample not equal to the expected code: store as new prev; good_cnt=0.
  - Illegal sample: prev_valid=0; good_cnt=0; no error reported.
- FSM, state LOCKED:
  - Expected code: update prev; stay in LOCKED.
  - Any other sample, legal or illegal, is an error:
    - err_pulse=1 for one cycle; err_count+1, saturating at 2^ERR_CNT_W-1.
    - locked=0 in the same output cycle; go to HUNT; good_cnt=0.
    - A legal wrong sample becomes the new prev (prev_valid=1). An illegal sample clears prev_valid.
- Reset mid-operation:
  - Next cycle all outputs are at their reset values and err_count is cleared.
  - The sample on the reset edge is discarded.

Test Plan:
- Reset, then in_valid=1 with 0001,0010,0100,1000,0001,0010 on consecutive edges -> idx 0,1,2,3,0,1 one cycle later, idx_valid=1 each cycle; locked=1 from the idx=2 output cycle onward; err_pulse never set.
- Locked, then ring_in=0110 -> idx_valid=0, idx holds, err_pulse=1 for one cycle, locked=0, err_count=1. Then 0001,0010,0100 -> locked=1 again on the 0100 output cycle.
- Locked at 0010, then 1000 (skip) -> idx_valid=1, idx=3, err_pulse=1, locked=0, err_count+1. Then 0001,0010 -> relock (1000 was kept as prev).
- Unlocked, then 0001, in_valid=0 for 3 cycles, then 0010, gap, 0100 -> idx_valid only on the sampled cycles; locked=1 after 0100; no error.
- ERR_CNT_W=2: lock, inject error, relock; repeat 5 times -> err_count sequence 1,2,3,3,3.
- Locked, assert rst for one edge while ring_in=0100 -> next cycle all outputs 0. Then 0000 in HUNT -> idx_valid=0, err_pulse=0, err_count=0.
